snake_game_ctrl: RTL and testbench

// - Game-control FSM directly downstream of keyboardcapture; consumes its eight held key levels
//   (up/down/left/right/start/resume/pause/escape).
// - Produces the game state, the current snake direction and a periodic move strobe for the

---
 rtl/snake_game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game-control FSM for the snake game. Synchronizes the eight held key levels from the
// keyboard front end, turns them into one-cycle press events, and produces the game state,
// the snake direction, a periodic move strobe, a restart strobe and the blanking flag.
// Optional speed-up of the move period is enabled by defining SNAKE_SPEEDUP_EN.
module snake_game_ctrl #(
  parameter int unsigned MOVE_DIV      = 25_000_000,
  parameter int unsigned SPEED_STEP    = 1_000_000,
  parameter int unsigned MOVE_DIV_MIN  = 5_000_000,
  parameter int unsigned SPEEDUP_MOVES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       resume,
  input  logic       pause,
  input  logic       escape,
  output logic [1:0] state,
  output logic [1:0] dir,
  output logic       move_tick,
  output logic       blank,
  output logic       restart
);

  localparam int unsigned PW = $clog2(MOVE_DIV + 1);

  localparam int unsigned KUp     = 0;
  localparam int unsigned KDown   = 1;
  localparam int unsigned KLeft   = 2;
  localparam int unsigned KRight  = 3;
  localparam int unsigned KStart  = 4;
  localparam int unsigned KResume = 5;
  localparam int unsigned KPause  = 6;
  localparam int unsigned KEsc    = 7;

  typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StPause = 2'b10, StBlack = 2'b11}
    state_e;
  typedef enum logic [1:0] {DirUp = 2'b00, DirDown = 2'b01, DirLeft = 2'b10, DirRight = 2'b11}
    dir_e;

  logic [7:0]    keys_raw;
  logic [7:0]    sync1_q, sync2_q, prev_q, ev_q;
  state_e        state_q, state_d;
  dir_e          dir_q, dir_d, pend_q, pend_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period;
  logic          tick_q, tick_d;
  logic          restart_q, restart_d;
  logic          run_stay;
  logic          dir_ok;

  assign keys_raw = {escape, pause, resume, start, right, left, down, up};

  // Two-flop synchronizer, edge history and registered rising-edge event per key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ev_q    <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ev_q    <= sync2_q & ~prev_q;
    end
  end

  // Game-state transitions; escape outranks start, start outranks pause, pause outranks resume
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ev_q[KEsc]) state_d = StBlack;
               else if (ev_q[KStart]) state_d = StRun;
      StRun:   if (ev_q[KEsc]) state_d = StBlack;
               else if (ev_q[KPause]) state_d = StPause;
      StPause: if (ev_q[KEsc]) state_d = StBlack;
               else if (ev_q[KResume]) state_d = StRun;
      StBlack: if (ev_q[KStart]) state_d = StRun;
    endcase
  end

  // Move timer, strobes and direction; a tick is suppressed on the cycle RUN is left
  always_comb begin
    restart_d = (state_d == StRun) && (state_q == StIdle || state_q == StBlack);
    run_stay  = (state_q == StRun) && (state_d == StRun);
    tick_d    = run_stay && (cnt_q == period - PW'(1));
    cnt_d     = cnt_q;
    if (restart_d)   cnt_d = '0;
    else if (tick_d) cnt_d = '0;
    else if (run_stay) cnt_d = cnt_q + PW'(1);

    dir_d = dir_q;
    if (restart_d)   dir_d = DirRight;
    else if (tick_d) dir_d = pend_q;

    // Reversal is judged against the direction in effect after this cycle, so a pending turn
    // committed on a tick can never be followed by its own opposite.
    dir_ok = run_stay && (ev_q[KEsc:KStart] == 4'b0);
    pend_d = pend_q;
    if (restart_d) begin
      pend_d = DirRight;
    end else if (dir_ok) begin
      if (ev_q[KUp] && dir_d != DirDown)         pend_d = DirUp;
      else if (ev_q[KDown] && dir_d != DirUp)    pend_d = DirDown;
      else if (ev_q[KLeft] && dir_d != DirRight) pend_d = DirLeft;
      else if (ev_q[KRight] && dir_d != DirLeft) pend_d = DirRight;
    end
  end

  // State, timer and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_q     <= DirRight;
      pend_q    <= DirRight;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      restart_q <= restart_d;
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam int unsigned MW = $clog2(SPEEDUP_MOVES) + 1;

  logic [MW-1:0] moves_q, moves_d;
  logic [PW-1:0] period_q, period_d;

  assign period = period_q;

  // Shorten the move period every SPEEDUP_MOVES ticks, saturating at the floor
  always_comb begin
    moves_d  = moves_q;
    period_d = period_q;
    if (restart_d) begin
      moves_d  = '0;
      period_d = PW'(MOVE_DIV);
    end else if (tick_d) begin
      if (moves_q == MW'(SPEEDUP_MOVES - 1)) begin
        moves_d  = '0;
        period_d = (32'(period_q) >= MOVE_DIV_MIN + SPEED_STEP) ?
                   period_q - PW'(SPEED_STEP) : PW'(MOVE_DIV_MIN);
      end else begin
        moves_d = moves_q + MW'(1);
      end
    end
  end

  // Speed-up registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moves_q  <= '0;
      period_q <= PW'(MOVE_DIV);
    end else begin
      moves_q  <= moves_d;
      period_q <= period_d;
    end
  end
`else
  assign period = PW'(MOVE_DIV);
`endif

  assign state     = state_q;
  assign dir       = dir_q;
  assign move_tick = tick_q;
  assign restart   = restart_q;
  assign blank     = (state_q == StBlack);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl with a short move period.
module tb_snake_game_ctrl;

  localparam logic [7:0] KUp     = 8'h01;
  localparam logic [7:0] KLeft   = 8'h04;
  localparam logic [7:0] KStart  = 8'h10;
  localparam logic [7:0] KResume = 8'h20;
  localparam logic [7:0] KPause  = 8'h40;
  localparam logic [7:0] KEsc    = 8'h80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up, down, left, right, start, resume, pause, escape;
  logic [1:0] state, dir;
  logic       move_tick, blank, restart;

  snake_game_ctrl #(
    .MOVE_DIV      (10),
    .SPEED_STEP    (2),
    .MOVE_DIV_MIN  (4),
    .SPEEDUP_MOVES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .start     (start),
    .resume    (resume),
    .pause     (pause),
    .escape    (escape),
    .state     (state),
    .dir       (dir),
    .move_tick (move_tick),
    .blank     (blank),
    .restart   (restart)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  bit sb_on = 1'b0;

  typedef struct {
    logic [7:0] keys;
    int         exp_state;
    int         exp_blank;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_keys(input logic [7:0] k);
    {escape, pause, resume, start, right, left, down, up} = k;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  // Expected gap before the n-th tick after a restart
  function automatic int gap(input int n);
`ifdef SNAKE_SPEEDUP_EN
    int p;
    p = 10 - 2 * ((n - 1) / 2);
    return (p < 4) ? 4 : p;
`else
    return 10;
`endif
  endfunction

  // Tick monitor: ticks only in RUN, and while scoreboarding each must match the queue head
  always @(posedge clk) begin
    #1;
    if (move_tick) begin
      chk("tick_in_run", int'(state), 1);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", cyc);
        end else begin
          chk("tick_cycle", cyc, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000 ns");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int e, t1, t2, t3, t4, r0, s, t;

    tbl.push_back('{KStart | KPause, 2, 0});
    tbl.push_back('{8'h00, 2, 0});
    tbl.push_back('{KStart, 2, 0});
    tbl.push_back('{8'h00, 2, 0});
    tbl.push_back('{KResume, 1, 0});
    tbl.push_back('{8'h00, 1, 0});
    tbl.push_back('{KPause | KEsc, 3, 1});
    tbl.push_back('{8'h00, 3, 1});
    tbl.push_back('{KPause, 3, 1});
    tbl.push_back('{KResume, 3, 1});
    tbl.push_back('{KStart, 1, 0});
    tbl.push_back('{KStart | KEsc, 3, 1});
    tbl.push_back('{KStart | KEsc | KResume, 3, 1});
    tbl.push_back('{8'h00, 3, 1});
    tbl.push_back('{KStart, 1, 0});

    set_keys(8'h00);
    rst_n = 1'b0;
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_dir", int'(dir), 3);
    chk("rst_tick", int'(move_tick), 0);
    chk("rst_blank", int'(blank), 0);
    chk("rst_restart", int'(restart), 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_hold", int'(state), 0);

    // Start from IDLE: RUN four clocks after the key edge
    set_keys(KStart);
    step(3);
    chk("idle_before_start", int'(state), 0);
    chk("no_early_restart", int'(restart), 0);
    step(1);
    chk("run_after_start", int'(state), 1);
    chk("restart_pulse", int'(restart), 1);
    chk("start_dir", int'(dir), 3);
    chk("start_blank", int'(blank), 0);
    e  = cyc;
    t1 = e + gap(1);
    t2 = t1 + gap(2);
    exp_q.push_back(t1);
    exp_q.push_back(t2);
    sb_on = 1'b1;
    step(1);
    chk("restart_one_cycle", int'(restart), 0);

    // Reversal is dropped; a later legal turn takes effect only on the tick
    set_keys(KStart | KLeft);
    goto(t1);
    chk("reverse_dropped", int'(dir), 3);
    set_keys(KStart | KLeft | KUp);
    goto(t2 - 1);
    chk("dir_before_tick", int'(dir), 3);
    goto(t2);
    chk("dir_on_tick", int'(dir), 0);
    chk("tick_seen", int'(move_tick), 1);
    set_keys(8'h00);

    // Pause with count held at 6, long hold, resume finishes the remaining count
    goto(t2 + 3);
    set_keys(KPause);
    step(4);
    chk("paused", int'(state), 2);
    step(100);
    chk("still_paused", int'(state), 2);
    set_keys(KPause | KResume);
    r0 = cyc;
    t3 = r0 + 4 + gap(3) - 6;
    t4 = t3 + gap(4);
    exp_q.push_back(t3);
    exp_q.push_back(t4);
    step(4);
    chk("resumed", int'(state), 1);
    goto(t4 + 1);

    // Escape from RUN blanks and stops ticks
    set_keys(KEsc);
    step(4);
    chk("black", int'(state), 3);
    chk("black_blank", int'(blank), 1);
    step(30);
    chk("black_hold", int'(state), 3);

    // Start from BLACK restores direction and period
    set_keys(KStart);
    step(4);
    chk("black_to_run", int'(state), 1);
    chk("black_restart", int'(restart), 1);
    chk("black_unblank", int'(blank), 0);
    chk("black_dir", int'(dir), 3);
    s = cyc;
    t = s;
    for (int n = 1; n <= 9; n++) begin
      t += gap(n);
      exp_q.push_back(t);
    end
    goto(t + 2);
    chk("sb_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // Table of key patterns and resulting state
    for (int i = 0; i < tbl.size(); i++) begin
      set_keys(tbl[i].keys);
      step(6);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].exp_state);
      chk($sformatf("tbl%0d_blank", i), int'(blank), tbl[i].exp_blank);
    end

    // Reset mid-period returns to IDLE at once
    step(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_tick", int'(move_tick), 0);
    chk("midrst_restart", int'(restart), 0);
    chk("midrst_dir", int'(dir), 3);
    set_keys(8'h00);
    #3;
    rst_n = 1'b1;
    step(5);
    chk("post_rst_idle", int'(state), 0);

    // IDLE ignores pause, escape goes to BLACK
    set_keys(KPause);
    step(6);
    chk("idle_pause_ignored", int'(state), 0);
    set_keys(KPause | KEsc);
    step(4);
    chk("idle_to_black", int'(state), 3);
    chk("idle_black_blank", int'(blank), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
